// File: rtl/frame_dispatch_ctrl.sv
// Read-side dispatcher for the parsed-frame FIFO: pops one entry at a time and
// serializes its payload onto the addressed channel. Define DISPATCH_TIMEOUT_EN for the SEND stall timeout.
module frame_dispatch_ctrl #(
  parameter int CH_NUM      = 8,
  parameter int DW          = 16,
  parameter int ENTRY_W     = 140,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic [ENTRY_W-1:0] data_from_fifo,
  input  logic [CH_NUM-1:0]  dout_ready,
  output logic [DW-1:0]      dout,
  output logic [CH_NUM-1:0]  dout_valid,
  output logic               frame_last,
  output logic               sel_err,
  output logic               timeout_err,
  output logic               busy,
  output logic [15:0]        frame_cnt
);
  localparam int PAY_W   = ENTRY_W - CH_NUM - 4;
  localparam int MAX_LEN = PAY_W / DW;
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

  state_t            state_q;
  logic [PAY_W-1:0]  payload_q;
  logic [CH_NUM-1:0] ch_q;
  logic [3:0]        len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DW-1:0]     dout_q;
  logic [CH_NUM-1:0] valid_q;
  logic              last_q;
  logic              sel_err_q;
  logic [15:0]       frame_cnt_q;
  logic [DW-1:0]     words [MAX_LEN];
  logic              beat;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;
`endif

  function automatic logic is_onehot(input logic [CH_NUM-1:0] v);
    is_onehot = (v != '0) && ((v & (v - CH_NUM'(1))) == '0);
  endfunction

  function automatic logic len_ok(input logic [3:0] len);
    len_ok = (len != 4'd0) && (len <= 4'(MAX_LEN));
  endfunction

  // Word 0 sits at the top of the left-justified payload.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_word
    assign words[g] = payload_q[PAY_W-1-DW*g -: DW];
  end

  assign beat = |(valid_q & dout_ready);

  // Reset gating keeps a pop from being lost while the FSM is held in IDLE.
  assign fifo_r_enable = (state_q == IDLE) && !fifo_empty && !rst;

  always_ff @(posedge clk_in) begin
    if (state_q == READ) begin
      payload_q <= data_from_fifo[ENTRY_W-1 -: PAY_W];
      ch_q      <= data_from_fifo[CH_NUM+3:4];
      len_q     <= data_from_fifo[3:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dout_q      <= '0;
      valid_q     <= '0;
      last_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      stall_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      sel_err_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= READ;
        end
        READ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          if (!is_onehot(ch_q) || !len_ok(len_q)) begin
            sel_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            idx_q   <= '0;
            dout_q  <= words[0];
            valid_q <= ch_q;
            last_q  <= (len_q == 4'd1);
`ifdef DISPATCH_TIMEOUT_EN
            stall_q <= '0;
`endif
            state_q <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
`ifdef DISPATCH_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (last_q) begin
              dout_q      <= '0;
              valid_q     <= '0;
              last_q      <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= IDLE;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              dout_q <= words[idx_q + IDX_W'(1)];
              last_q <= (({1'b0, idx_q} + 4'd2) == len_q);
            end
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            dout_q    <= '0;
            valid_q   <= '0;
            last_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_last = last_q;
  assign sel_err    = sel_err_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_cnt_q;

`ifdef DISPATCH_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout_err = 1'b0;
`endif

endmodule
